// File: rtl/psram_pkg.sv
// Shared PSRAM protocol definitions: opcodes, responder FSM states and line-mode constants.
// The controller imports the opcode constants from here as well.
package psram_pkg;

  localparam logic [7:0] OP_READ           = 8'h03;
  localparam logic [7:0] OP_FAST_READ      = 8'h0B;
  localparam logic [7:0] OP_FAST_READ_QUAD = 8'hEB;
  localparam logic [7:0] OP_WRITE          = 8'h02;
  localparam logic [7:0] OP_WRITE_QUAD     = 8'h38;
  localparam logic [7:0] OP_ENTER_QUAD     = 8'h35;
  localparam logic [7:0] OP_EXIT_QUAD      = 8'hF5;
  localparam logic [7:0] OP_RESET_ENABLE   = 8'h66;
  localparam logic [7:0] OP_RESET          = 8'h99;
  localparam logic [7:0] OP_READ_ID        = 8'h9F;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_ID,
    ST_IGNORE
  } state_e;

  // Phase that follows the address phase.
  typedef enum logic [1:0] {
    POST_READ,
    POST_FAST_READ,
    POST_WRITE,
    POST_ID
  } post_e;

  localparam logic       LINE_SPI  = 1'b0;
  localparam logic       LINE_QUAD = 1'b1;
  localparam logic [3:0] OE_SPI    = 4'b0010;
  localparam logic [3:0] OE_QUAD   = 4'b1111;

  // Byte idx (0 = first streamed) of the concatenated {MFID, KGD, EID} word.
  function automatic logic [7:0] id_byte(input logic [63:0] word, input logic [2:0] idx);
    logic [5:0] lsb;
    lsb = {3'd7 - idx, 3'b000};
    return word[lsb +: 8];
  endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// Single-port byte array backing the PSRAM responder.
// Writes land on the rising sclk edge; reads are combinational so data can launch on the next falling edge.
module psram_resp_mem #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 psram_sclk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [7:0]           wdata_i,
  output logic [7:0]           rdata_o
);

  logic [7:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge psram_sclk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/psram_spi_responder.sv
// Device side of an IPS6404L-SQ style SPI/QPI PSRAM link, backed by a small internal byte array.
// Inputs sampled on rising sclk, outputs launched on falling sclk; ce_n high clears the frame.
module psram_spi_responder
  import psram_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned FAST_WAIT_SPI  = 8,
  parameter int unsigned FAST_WAIT_QUAD = 6,
  parameter logic [7:0]  MFID           = 8'h0D,
  parameter logic [7:0]  KGD            = 8'h5D,
  parameter logic [47:0] EID            = 48'h0000_0000_0000
) (
  input  logic       reset,
  input  logic       psram_sclk,
  input  logic       psram_ce_n,
  input  logic [3:0] psram_sio_in,
  output logic [3:0] psram_sio_out,
  output logic [3:0] psram_sio_oe,
  output logic       quad_mode,
  output logic [7:0] last_cmd,
  output logic       cmd_err
);

  localparam logic [7:0]  WAIT_SPI_LAST  = 8'(FAST_WAIT_SPI - 1);
  localparam logic [7:0]  WAIT_QUAD_LAST = 8'(FAST_WAIT_QUAD - 1);
  localparam logic [63:0] ID_WORD        = {MFID, KGD, EID};

  // Per-frame state, cleared whenever ce_n is high.
  state_e               state_q, state_d;
  post_e                post_q, post_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [6:0]           shift_q, shift_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 wide_q, wide_d;

  // State that survives across frames.
  logic                 quad_q, quad_d;
  logic                 rst_en_q, rst_en_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [7:0]           last_cmd_q, last_cmd_d;

  logic [3:0]           out_q, out_d;
  logic [3:0]           oe_q, oe_d;

  logic                 line_wide;
  logic                 byte_last;
  logic                 addr_last;
  logic [7:0]           byte_in;
  logic [7:0]           mem_rdata;
  logic [7:0]           rd_byte;
  logic                 mem_we;

  psram_resp_mem #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .psram_sclk(psram_sclk),
    .we_i      (mem_we),
    .addr_i    (addr_q),
    .wdata_i   (byte_in),
    .rdata_o   (mem_rdata)
  );

  // The opcode width follows the latched mode; every later phase follows the decoded opcode.
  assign line_wide = (state_q == ST_CMD) ? quad_q : wide_q;
  assign byte_in   = line_wide ? {shift_q[3:0], psram_sio_in} : {shift_q, psram_sio_in[0]};
  assign byte_last = line_wide ? (cnt_q == 8'd1) : (cnt_q == 8'd7);
  assign addr_last = wide_q ? (cnt_q == 8'd5) : (cnt_q == 8'd23);

  always_comb begin
    state_d    = state_q;
    post_d     = post_q;
    cnt_d      = cnt_q + 8'd1;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wide_d     = wide_q;
    quad_d     = quad_q;
    rst_en_d   = rst_en_q;
    cmd_err_d  = cmd_err_q;
    last_cmd_d = last_cmd_q;
    mem_we     = 1'b0;

    case (state_q)
      ST_CMD: begin
        shift_d = byte_in[6:0];
        if (byte_last && !psram_ce_n) begin
          cnt_d      = 8'd0;
          last_cmd_d = byte_in;
          state_d    = ST_IGNORE;
          case ({quad_q, byte_in})
            {LINE_SPI, OP_READ}: begin
              state_d = ST_ADDR; wide_d = LINE_SPI; post_d = POST_READ;
            end
            {LINE_SPI, OP_FAST_READ}: begin
              state_d = ST_ADDR; wide_d = LINE_SPI; post_d = POST_FAST_READ;
            end
            {LINE_SPI, OP_FAST_READ_QUAD}, {LINE_QUAD, OP_FAST_READ},
            {LINE_QUAD, OP_FAST_READ_QUAD}: begin
              state_d = ST_ADDR; wide_d = LINE_QUAD; post_d = POST_FAST_READ;
            end
            {LINE_SPI, OP_WRITE}: begin
              state_d = ST_ADDR; wide_d = LINE_SPI; post_d = POST_WRITE;
            end
            {LINE_SPI, OP_WRITE_QUAD}, {LINE_QUAD, OP_WRITE},
            {LINE_QUAD, OP_WRITE_QUAD}: begin
              state_d = ST_ADDR; wide_d = LINE_QUAD; post_d = POST_WRITE;
            end
            {LINE_SPI, OP_READ_ID}: begin
              state_d = ST_ADDR; wide_d = LINE_SPI; post_d = POST_ID;
            end
            {LINE_SPI, OP_ENTER_QUAD}:  quad_d = 1'b1;
            {LINE_QUAD, OP_EXIT_QUAD}:  quad_d = 1'b0;
            {LINE_SPI, OP_RESET_ENABLE}, {LINE_QUAD, OP_RESET_ENABLE}: rst_en_d = 1'b1;
            {LINE_SPI, OP_RESET}, {LINE_QUAD, OP_RESET}: begin
              if (rst_en_q) begin
                quad_d    = 1'b0;
                cmd_err_d = 1'b0;
                rst_en_d  = 1'b0;
              end
            end
            // SPI-only opcodes sent in QPI are dropped without flagging an error.
            {LINE_QUAD, OP_READ_ID}, {LINE_QUAD, OP_READ}, {LINE_QUAD, OP_ENTER_QUAD}: begin
            end
            default: begin
              rst_en_d  = 1'b0;
              cmd_err_d = 1'b1;
            end
          endcase
        end
      end
      ST_ADDR: begin
        addr_d = wide_q ? {addr_q[ADDR_BITS-5:0], psram_sio_in}
                        : {addr_q[ADDR_BITS-2:0], psram_sio_in[0]};
        if (addr_last) begin
          cnt_d = 8'd0;
          case (post_q)
            POST_READ:      state_d = ST_RDATA;
            POST_FAST_READ: state_d = ST_WAIT;
            POST_WRITE:     state_d = ST_WDATA;
            POST_ID: begin
              state_d = ST_ID;
              addr_d  = '0;
            end
          endcase
        end
      end
      ST_WAIT: begin
        if (cnt_q == (wide_q ? WAIT_QUAD_LAST : WAIT_SPI_LAST)) begin
          cnt_d   = 8'd0;
          state_d = ST_RDATA;
        end
      end
      ST_RDATA, ST_ID: begin
        if (byte_last) begin
          cnt_d  = 8'd0;
          addr_d = addr_q + 1'b1;
        end
      end
      ST_WDATA: begin
        shift_d = byte_in[6:0];
        if (byte_last) begin
          cnt_d  = 8'd0;
          addr_d = addr_q + 1'b1;
          mem_we = !psram_ce_n;
        end
      end
      ST_IGNORE: cnt_d = cnt_q;
      default:   state_d = ST_IGNORE;
    endcase
  end

  always_ff @(posedge psram_sclk or posedge reset or posedge psram_ce_n) begin
    if (reset || psram_ce_n) begin
      state_q <= ST_CMD;
      post_q  <= POST_READ;
      cnt_q   <= 8'd0;
      shift_q <= 7'd0;
      addr_q  <= '0;
      wide_q  <= LINE_SPI;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wide_q  <= wide_d;
    end
  end

  always_ff @(posedge psram_sclk or posedge reset) begin
    if (reset) begin
      quad_q     <= 1'b0;
      rst_en_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      last_cmd_q <= 8'h00;
    end else begin
      quad_q     <= quad_d;
      rst_en_q   <= rst_en_d;
      cmd_err_q  <= cmd_err_d;
      last_cmd_q <= last_cmd_d;
    end
  end

  // cnt_q counts bits already sampled by the host, so it indexes the bit to launch next.
  always_comb begin
    out_d   = 4'h0;
    oe_d    = 4'h0;
    rd_byte = (state_q == ST_ID) ? id_byte(ID_WORD, addr_q[2:0]) : mem_rdata;
    if (state_q == ST_RDATA || state_q == ST_ID) begin
      if (wide_q) begin
        oe_d  = OE_QUAD;
        out_d = cnt_q[0] ? rd_byte[3:0] : rd_byte[7:4];
      end else begin
        oe_d  = OE_SPI;
        out_d = {2'b00, rd_byte[3'd7 - cnt_q[2:0]], 1'b0};
      end
    end
  end

  always_ff @(negedge psram_sclk or posedge reset or posedge psram_ce_n) begin
    if (reset || psram_ce_n) begin
      out_q <= 4'h0;
      oe_q  <= 4'h0;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
    end
  end

  assign psram_sio_out = out_q;
  assign psram_sio_oe  = oe_q;
  assign quad_mode     = quad_q;
  assign last_cmd      = last_cmd_q;
  assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_psram_spi_responder.sv
// Directed bench for psram_spi_responder: a host-side driver plus a byte-array/mode model,
// with one process comparing SIO outputs against the model every frame cycle.
module tb_psram_spi_responder;

  logic       reset;
  logic       psram_sclk;
  logic       psram_ce_n;
  logic [3:0] psram_sio_in;
  logic [3:0] psram_sio_out;
  logic [3:0] psram_sio_oe;
  logic       quad_mode;
  logic [7:0] last_cmd;
  logic       cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectations for the current frame cycle, set by the driver at each falling edge.
  logic       chk_en, chk_oe;
  logic [3:0] exp_oe, exp_mask, exp_out;

  // Model: byte store plus the mode/error rules of the command set.
  logic [7:0] model_mem [0:1023];
  logic [7:0] id_bytes [0:7];
  logic       m_quad, m_err, m_rsten;
  logic [7:0] m_last;

  logic [7:0] g0, g1;

  psram_spi_responder dut (
    .reset        (reset),
    .psram_sclk   (psram_sclk),
    .psram_ce_n   (psram_ce_n),
    .psram_sio_in (psram_sio_in),
    .psram_sio_out(psram_sio_out),
    .psram_sio_oe (psram_sio_oe),
    .quad_mode    (quad_mode),
    .last_cmd     (last_cmd),
    .cmd_err      (cmd_err)
  );

  initial psram_sclk = 1'b0;
  always #5 psram_sclk = ~psram_sclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge psram_sclk) begin
    #2;
    if (chk_en) begin
      if (chk_oe) check("sio_oe", {28'd0, psram_sio_oe}, {28'd0, exp_oe});
      if (exp_mask != 4'h0)
        check("sio_out", {28'd0, psram_sio_out & exp_mask}, {28'd0, exp_out & exp_mask});
    end
  end

  task automatic model_cmd(input logic [7:0] op);
    m_last = op;
    if (op == 8'h66) begin
      m_rsten = 1'b1;
    end else if (op == 8'h99) begin
      if (m_rsten) begin
        m_quad = 1'b0; m_err = 1'b0; m_rsten = 1'b0;
      end
    end else if (!m_quad && (op inside {8'h03, 8'h0B, 8'hEB, 8'h02, 8'h38, 8'h9F})) begin
    end else if (!m_quad && op == 8'h35) begin
      m_quad = 1'b1;
    end else if (m_quad && (op inside {8'h0B, 8'hEB, 8'h02, 8'h38})) begin
    end else if (m_quad && op == 8'hF5) begin
      m_quad = 1'b0;
    end else if (m_quad && (op inside {8'h9F, 8'h03, 8'h35})) begin
    end else begin
      m_rsten = 1'b0; m_err = 1'b1;
    end
  endtask

  task automatic check_status();
    check("quad_mode", {31'd0, quad_mode}, {31'd0, m_quad});
    check("cmd_err", {31'd0, cmd_err}, {31'd0, m_err});
    check("last_cmd", {24'd0, last_cmd}, {24'd0, m_last});
  endtask

  task automatic cyc(input logic [3:0] v, input logic co, input logic [3:0] eoe,
                     input logic [3:0] emask, input logic [3:0] eout);
    @(negedge psram_sclk);
    psram_ce_n   = 1'b0;
    psram_sio_in = v;
    chk_en       = 1'b1;
    chk_oe       = co;
    exp_oe       = eoe;
    exp_mask     = emask;
    exp_out      = eout;
  endtask

  task automatic drv(input logic [3:0] v);
    cyc(v, 1'b1, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic end_frame();
    @(negedge psram_sclk);
    psram_ce_n   = 1'b1;
    psram_sio_in = 4'h0;
    chk_en       = 1'b0;
    #1 check("oe_after_ce", {28'd0, psram_sio_oe}, 32'd0);
    @(negedge psram_sclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic q);
    if (q) begin
      drv(b[7:4]);
      drv(b[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) drv({3'b000, b[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a, input logic q);
    if (q) begin
      for (int i = 5; i >= 0; i--) drv(a[i*4 +: 4]);
    end else begin
      for (int i = 23; i >= 0; i--) drv({3'b000, a[i]});
    end
  endtask

  task automatic read_byte(input logic q, input logic is_id, input logic [7:0] expb,
                           output logic [7:0] got);
    got = 8'h00;
    if (q) begin
      cyc(4'h0, 1'b1, 4'hF, 4'hF, expb[7:4]);
      #1 got[7:4] = psram_sio_out;
      cyc(4'h0, 1'b1, 4'hF, 4'hF, expb[3:0]);
      #1 got[3:0] = psram_sio_out;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        cyc(4'h0, !is_id, 4'b0010, 4'b0010, {2'b00, expb[i], 1'b0});
        #1 got[i] = psram_sio_out[1];
      end
    end
  endtask

  task automatic cmd_frame(input logic [7:0] op);
    send_byte(op, m_quad);
    end_frame();
    model_cmd(op);
    check_status();
  endtask

  task automatic write2(input logic [7:0] op, input logic [23:0] a,
                        input logic [7:0] d0, input logic [7:0] d1);
    logic q;
    q = m_quad || (op == 8'h38);
    send_byte(op, m_quad);
    send_addr(a, q);
    send_byte(d0, q);
    send_byte(d1, q);
    end_frame();
    model_mem[int'(a) % 1024]       = d0;
    model_mem[(int'(a) + 1) % 1024] = d1;
    model_cmd(op);
    check_status();
  endtask

  task automatic read_n(input logic [7:0] op, input logic [23:0] a, input int n,
                        output logic [7:0] r0, output logic [7:0] r1);
    logic       q;
    int         waits;
    logic [7:0] g;
    q     = m_quad || (op == 8'hEB);
    waits = (op == 8'h03) ? 0 : (q ? 6 : 8);
    r0    = 8'h00;
    r1    = 8'h00;
    send_byte(op, m_quad);
    send_addr(a, q);
    repeat (waits) drv(4'h0);
    for (int k = 0; k < n; k++) begin
      read_byte(q, 1'b0, model_mem[(int'(a) + k) % 1024], g);
      if (k == 0) r0 = g;
      if (k == 1) r1 = g;
    end
    end_frame();
    model_cmd(op);
    check_status();
  endtask

  task automatic read_id(input int n, output logic [7:0] r0, output logic [7:0] r1);
    logic [7:0] g;
    r0 = 8'h00;
    r1 = 8'h00;
    send_byte(8'h9F, 1'b0);
    send_addr(24'hFFFFFF, 1'b0);
    for (int k = 0; k < n; k++) begin
      read_byte(1'b0, 1'b1, id_bytes[k % 8], g);
      if (k == 0) r0 = g;
      if (k == 1) r1 = g;
    end
    end_frame();
    model_cmd(8'h9F);
    check_status();
  endtask

  initial begin
    reset        = 1'b1;
    psram_ce_n   = 1'b1;
    psram_sio_in = 4'h0;
    chk_en       = 1'b0;
    chk_oe       = 1'b0;
    exp_oe       = 4'h0;
    exp_mask     = 4'h0;
    exp_out      = 4'h0;
    m_quad       = 1'b0;
    m_err        = 1'b0;
    m_rsten      = 1'b0;
    m_last       = 8'h00;
    id_bytes[0]  = 8'h0D;
    id_bytes[1]  = 8'h5D;
    for (int i = 2; i < 8; i++) id_bytes[i] = 8'h00;

    repeat (3) @(negedge psram_sclk);
    #1;
    check("rst_oe", {28'd0, psram_sio_oe}, 32'd0);
    check("rst_out", {28'd0, psram_sio_out}, 32'd0);
    check("rst_quad", {31'd0, quad_mode}, 32'd0);
    check("rst_last_cmd", {24'd0, last_cmd}, 32'd0);
    check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    @(negedge psram_sclk);
    reset = 1'b0;

    // Reset sequence, then the ID stream including its wrap back to MFID.
    cmd_frame(8'h66);
    cmd_frame(8'h99);
    read_id(9, g0, g1);
    check("id_mfid", {24'd0, g0}, 32'h0D);
    check("id_kgd", {24'd0, g1}, 32'h5D);
    check("id_quad_off", {31'd0, quad_mode}, 32'd0);

    // SPI write, plain read, fast read with 8 wait clocks.
    write2(8'h02, 24'h000010, 8'hA5, 8'h3C);
    read_n(8'h03, 24'h000010, 2, g0, g1);
    check("rd03_b0", {24'd0, g0}, 32'hA5);
    check("rd03_b1", {24'd0, g1}, 32'h3C);
    read_n(8'h0B, 24'h000010, 2, g0, g1);
    check("rd0B_b0", {24'd0, g0}, 32'hA5);
    check("rd0B_b1", {24'd0, g1}, 32'h3C);

    // QPI: quad write across the top of the array, quad read wraps to 0.
    cmd_frame(8'h35);
    check("enter_quad", {31'd0, quad_mode}, 32'd1);
    write2(8'h38, 24'h0003FF, 8'h11, 8'h22);
    read_n(8'hEB, 24'h0003FF, 2, g0, g1);
    check("rdEB_3ff", {24'd0, g0}, 32'h11);
    check("rdEB_wrap", {24'd0, g1}, 32'h22);

    // Exit QPI; following frames decode in 1-bit mode.
    cmd_frame(8'hF5);
    check("exit_quad", {31'd0, quad_mode}, 32'd0);

    // Partial write byte aborted by ce_n must leave the array unchanged.
    write2(8'h02, 24'h000020, 8'h77, 8'h88);
    send_byte(8'h02, 1'b0);
    send_addr(24'h000020, 1'b0);
    drv(4'h1); drv(4'h0); drv(4'h1); drv(4'h0); drv(4'h1);
    end_frame();
    model_cmd(8'h02);
    check_status();
    read_n(8'h03, 24'h000020, 1, g0, g1);
    check("abort_keeps", {24'd0, g0}, 32'h77);

    // Unsupported opcode: sticky error, no SIO drive while the frame runs on.
    send_byte(8'h5A, 1'b0);
    repeat (8) drv(4'hF);
    end_frame();
    model_cmd(8'h5A);
    check_status();
    check("err_set", {31'd0, cmd_err}, 32'd1);
    cmd_frame(8'h66);
    cmd_frame(8'h99);
    check("err_clear", {31'd0, cmd_err}, 32'd0);

    // Reset in the middle of a quad read.
    cmd_frame(8'h35);
    send_byte(8'hEB, 1'b1);
    send_addr(24'h000010, 1'b1);
    repeat (6) drv(4'h0);
    read_byte(1'b1, 1'b0, model_mem[16], g0);
    check("pre_reset_rd", {24'd0, g0}, 32'hA5);
    @(negedge psram_sclk);
    chk_en = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("midrst_oe", {28'd0, psram_sio_oe}, 32'd0);
    check("midrst_out", {28'd0, psram_sio_out}, 32'd0);
    check("midrst_quad", {31'd0, quad_mode}, 32'd0);
    check("midrst_last", {24'd0, last_cmd}, 32'd0);
    psram_ce_n = 1'b1;
    @(negedge psram_sclk);
    reset   = 1'b0;
    m_quad  = 1'b0;
    m_err   = 1'b0;
    m_rsten = 1'b0;
    m_last  = 8'h00;
    read_id(2, g0, g1);
    check("post_rst_mfid", {24'd0, g0}, 32'h0D);
    check("post_rst_kgd", {24'd0, g1}, 32'h5D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
